// File: rtl/spu_register_file_if.sv
// Register-read bundle for the SPU register file: six operand reads (two issue
// slots x RA/RB/RC) and two writebacks from the execute pipes.
interface spu_register_file_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] readRegisterRA_1, readRegisterRB_1, readRegisterRC_1;
  logic [ADDR_WIDTH-1:0] readRegisterRA_2, readRegisterRB_2, readRegisterRC_2;
  logic                  writeEnable_WB1, writeEnable_WB2;
  logic [ADDR_WIDTH-1:0] writeRegister_WB1, writeRegister_WB2;
  logic [DATA_WIDTH-1:0] writeData_WB1, writeData_WB2;
  logic [DATA_WIDTH-1:0] readDataRA_1, readDataRB_1, readDataRC_1;
  logic [DATA_WIDTH-1:0] readDataRA_2, readDataRB_2, readDataRC_2;

  modport master (
    output readRegisterRA_1, readRegisterRB_1, readRegisterRC_1,
           readRegisterRA_2, readRegisterRB_2, readRegisterRC_2,
           writeEnable_WB1, writeRegister_WB1, writeData_WB1,
           writeEnable_WB2, writeRegister_WB2, writeData_WB2,
    input  readDataRA_1, readDataRB_1, readDataRC_1,
           readDataRA_2, readDataRB_2, readDataRC_2
  );

  modport slave (
    input  readRegisterRA_1, readRegisterRB_1, readRegisterRC_1,
           readRegisterRA_2, readRegisterRB_2, readRegisterRC_2,
           writeEnable_WB1, writeRegister_WB1, writeData_WB1,
           writeEnable_WB2, writeRegister_WB2, writeData_WB2,
    output readDataRA_1, readDataRB_1, readDataRC_1,
           readDataRA_2, readDataRB_2, readDataRC_2
  );
endinterface

// File: rtl/spu_register_file.sv
// Unified SPU register file: 6 combinational read ports, 2 write ports, with
// optional same-cycle write-through forwarding. Pipe 2 (younger) wins collisions.
module spu_register_file #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_REGS   = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int BYPASS_EN  = 1
) (
  input logic clk,
  input logic reset,
  spu_register_file_if.slave rf
);
  localparam int NUM_RD = 6;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [ADDR_WIDTH-1:0] w_idx [NUM_RD];
  logic [DATA_WIDTH-1:0] w_rd  [NUM_RD];

  assign w_idx[0] = rf.readRegisterRA_1;
  assign w_idx[1] = rf.readRegisterRB_1;
  assign w_idx[2] = rf.readRegisterRC_1;
  assign w_idx[3] = rf.readRegisterRA_2;
  assign w_idx[4] = rf.readRegisterRB_2;
  assign w_idx[5] = rf.readRegisterRC_2;

  assign rf.readDataRA_1 = w_rd[0];
  assign rf.readDataRB_1 = w_rd[1];
  assign rf.readDataRC_1 = w_rd[2];
  assign rf.readDataRA_2 = w_rd[3];
  assign rf.readDataRB_2 = w_rd[4];
  assign rf.readDataRC_2 = w_rd[5];

  // WB2 is written last so its non-blocking update overrides WB1 on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      if (rf.writeEnable_WB1) r_mem[rf.writeRegister_WB1] <= rf.writeData_WB1;
      if (rf.writeEnable_WB2) r_mem[rf.writeRegister_WB2] <= rf.writeData_WB2;
    end
  end

  // Forwarding priority mirrors the write order, so a bypassed read equals
  // what the array will hold next cycle.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd[p] = r_mem[w_idx[p]];
      if (BYPASS_EN != 0 && !reset) begin
        if (rf.writeEnable_WB2 && rf.writeRegister_WB2 == w_idx[p])
          w_rd[p] = rf.writeData_WB2;
        else if (rf.writeEnable_WB1 && rf.writeRegister_WB1 == w_idx[p])
          w_rd[p] = rf.writeData_WB1;
      end
    end
  end
endmodule

// File: tb/tb_spu_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file driven
// with identical stimulus, checked against hand-computed values.
module tb_spu_register_file;
  localparam int DW = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] idx [6];
  logic          we1, we2;
  logic [AW-1:0] wr1, wr2;
  logic [DW-1:0] wd1, wd2;

  spu_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();
  spu_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifn ();

  assign ifb.readRegisterRA_1 = idx[0];
  assign ifb.readRegisterRB_1 = idx[1];
  assign ifb.readRegisterRC_1 = idx[2];
  assign ifb.readRegisterRA_2 = idx[3];
  assign ifb.readRegisterRB_2 = idx[4];
  assign ifb.readRegisterRC_2 = idx[5];
  assign ifb.writeEnable_WB1 = we1;
  assign ifb.writeRegister_WB1 = wr1;
  assign ifb.writeData_WB1 = wd1;
  assign ifb.writeEnable_WB2 = we2;
  assign ifb.writeRegister_WB2 = wr2;
  assign ifb.writeData_WB2 = wd2;

  assign ifn.readRegisterRA_1 = idx[0];
  assign ifn.readRegisterRB_1 = idx[1];
  assign ifn.readRegisterRC_1 = idx[2];
  assign ifn.readRegisterRA_2 = idx[3];
  assign ifn.readRegisterRB_2 = idx[4];
  assign ifn.readRegisterRC_2 = idx[5];
  assign ifn.writeEnable_WB1 = we1;
  assign ifn.writeRegister_WB1 = wr1;
  assign ifn.writeData_WB1 = wd1;
  assign ifn.writeEnable_WB2 = we2;
  assign ifn.writeRegister_WB2 = wr2;
  assign ifn.writeData_WB2 = wd2;

  spu_register_file #(.DATA_WIDTH(DW), .NUM_REGS(128), .ADDR_WIDTH(AW), .BYPASS_EN(1))
    u_dut_byp (.clk(clk), .reset(reset), .rf(ifb));
  spu_register_file #(.DATA_WIDTH(DW), .NUM_REGS(128), .ADDR_WIDTH(AW), .BYPASS_EN(0))
    u_dut_nob (.clk(clk), .reset(reset), .rf(ifn));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 1'b0; we2 = 1'b0; wr1 = '0; wr2 = '0; wd1 = '0; wd2 = '0;
  endtask

  task automatic rd_all(input logic [AW-1:0] r);
    for (int p = 0; p < 6; p++) idx[p] = r;
  endtask

  localparam logic [DW-1:0] V5  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [DW-1:0] VAA = {8{16'hAAAA}};
  localparam logic [DW-1:0] V55 = {8{16'h5555}};

  initial begin
    idle();
    rd_all('0);
    #1;
    // seed a nonzero value so reset clearing is observable
    we1 = 1'b1; wr1 = 7'd100; wd1 = 128'hDEAD;
    tick();
    idle();
    idx[0] = 7'd100; #1;
    chk("pre_rst_seed", ifb.readDataRA_1, 128'hDEAD);

    reset = 1'b1;
    tick();
    // second reset cycle: pending write to 40 must be dropped and not forwarded
    we2 = 1'b1; wr2 = 7'd40; wd2 = 128'hFF;
    idx[0] = 7'd40; #1;
    chk("rst_no_byp", ifb.readDataRA_1, '0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_drop40", ifb.readDataRA_1, '0);

    for (int i = 0; i < 128; i++) begin
      for (int p = 0; p < 6; p++) idx[p] = 7'((i + p * 21) % 128);
      #1;
      chk("rst_zero", ifb.readDataRA_1 | ifb.readDataRB_1 | ifb.readDataRC_1 |
                      ifb.readDataRA_2 | ifb.readDataRB_2 | ifb.readDataRC_2 |
                      ifn.readDataRA_1 | ifn.readDataRC_2, '0);
    end

    we2 = 1'b1; wr2 = 7'd40; wd2 = 128'hFF;
    tick();
    idle();
    idx[0] = 7'd40; #1;
    chk("wr40", ifb.readDataRA_1, 128'hFF);

    we1 = 1'b1; wr1 = 7'd5; wd1 = V5;
    tick();
    idle();
    idx[0] = 7'd5; idx[5] = 7'd5; idx[1] = 7'd6; #1;
    chk("ra1_r5", ifb.readDataRA_1, V5);
    chk("rc2_r5", ifb.readDataRC_2, V5);
    chk("nob_rc2_r5", ifn.readDataRC_2, V5);
    chk("r6_zero", ifb.readDataRB_1, '0);

    we1 = 1'b1; wr1 = 7'd10; wd1 = VAA;
    we2 = 1'b1; wr2 = 7'd11; wd2 = V55;
    tick();
    idle();
    idx[3] = 7'd10; idx[4] = 7'd11; #1;
    chk("ra2_r10", ifb.readDataRA_2, VAA);
    chk("rb2_r11", ifb.readDataRB_2, V55);

    we1 = 1'b1; wr1 = 7'd20; wd1 = 128'h1;
    we2 = 1'b1; wr2 = 7'd20; wd2 = 128'h2;
    tick();
    idle();
    idx[2] = 7'd20; #1;
    chk("coll_r20", ifb.readDataRC_1, 128'h2);
    chk("nob_coll_r20", ifn.readDataRC_1, 128'h2);

    we1 = 1'b1; wr1 = 7'd0; wd1 = 128'h55;
    tick();
    idle();
    idx[0] = 7'd0; #1;
    chk("r0_plain", ifb.readDataRA_1, 128'h55);

    we1 = 1'b1; wr1 = 7'd30; wd1 = 128'h7;
    tick();
    idle();
    we1 = 1'b1; wr1 = 7'd30; wd1 = 128'h9;
    idx[1] = 7'd30; #1;
    chk("byp_wb1", ifb.readDataRB_1, 128'h9);
    chk("nob_wb1", ifn.readDataRB_1, 128'h7);
    tick();
    we1 = 1'b1; wr1 = 7'd30; wd1 = 128'h9;
    we2 = 1'b1; wr2 = 7'd30; wd2 = 128'hC;
    #1;
    chk("byp_wb2_pri", ifb.readDataRB_1, 128'hC);
    chk("nob_wb2_pri", ifn.readDataRB_1, 128'h9);
    tick();
    idle();
    #1;
    chk("r30_after", ifb.readDataRB_1, 128'hC);
    chk("nob_r30_after", ifn.readDataRB_1, 128'hC);

    // WB2 active on another register: WB1 must still forward
    we1 = 1'b1; wr1 = 7'd30; wd1 = 128'hE;
    we2 = 1'b1; wr2 = 7'd31; wd2 = 128'hF;
    idx[1] = 7'd30; idx[4] = 7'd31; #1;
    chk("byp_wb1_only", ifb.readDataRB_1, 128'hE);
    chk("byp_wb2_other", ifb.readDataRB_2, 128'hF);
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
